// File: rtl/tow_press_pulser_if.sv
// rtl/tow_press_pulser_if.sv - button/pulse bundle between playfield logic and the press pulser
// Purpose: carries the raw buttons, the game enable and the resulting move pulses/press counts.
// Signals:
//   keyL_raw, keyR_raw  raw asynchronous player buttons
//   enable              game running; 0 suppresses move pulses
//   L, R                one-cycle move pulses
//   pressCountL/R       saturating counts of accepted pulses
// Modports: master drives buttons/enable, slave (the pulser) drives pulses/counts.
interface tow_press_pulser_if #(
   parameter int CNT_W = 8
);
   logic             keyL_raw;
   logic             keyR_raw;
   logic             enable;
   logic             L;
   logic             R;
   logic [CNT_W-1:0] pressCountL;
   logic [CNT_W-1:0] pressCountR;

   modport master (
      output keyL_raw, keyR_raw, enable,
      input  L, R, pressCountL, pressCountR
   );

   modport slave (
      input  keyL_raw, keyR_raw, enable,
      output L, R, pressCountL, pressCountR
   );
endinterface

// File: rtl/tow_press_pulser.sv
// rtl/tow_press_pulser.sv - debounced single-pulse generator for the two tug-of-war buttons
// Purpose: synchronises each raw button, debounces it with a four-state FSM and emits exactly
//          one registered pulse per accepted press, gated by enable; keeps saturating counts.
// Ports:
//   Clock   system clock, rising edge
//   reset   synchronous, active-high
//   bus     tow_press_pulser_if.slave (keyL_raw/keyR_raw/enable in, L/R/pressCountL/R out)
// Parameters: DEBOUNCE_CYCLES (>=4), ACTIVE_LOW (1 = button reads 0 when pressed), CNT_W.
module tow_press_pulser #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int CNT_W           = 8
) (
   input logic             Clock,
   input logic             reset,
   tow_press_pulser_if.slave bus
);
   // cnt never exceeds DEBOUNCE_CYCLES-1, so clog2 of the count itself is enough.
   localparam int            CW           = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          RELEASED_LVL = ACTIVE_LOW;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   logic [1:0] raw;
   assign raw = {bus.keyR_raw, bus.keyL_raw};

   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic             sync1;
      logic             sync2;
      logic             pressed;
      state_t           state;
      state_t           state_nx;
      logic [CW-1:0]    cnt;
      logic [CW-1:0]    cnt_nx;
      logic             fire;
      logic             pulse_q;
      logic [CNT_W-1:0] count_q;

      always_ff @(posedge Clock) begin
         if (reset) begin
            sync1 <= RELEASED_LVL;
            sync2 <= RELEASED_LVL;
         end else begin
            sync1 <= raw[ch];
            sync2 <= sync1;
         end
      end

      // Normalise polarity: pressed = 1 regardless of board wiring.
      assign pressed = sync2 ^ ACTIVE_LOW;

      // Starting in RELEASE_CHK means a button held through reset settles into HELD
      // without firing, and a released one must prove itself before a press counts.
      always_ff @(posedge Clock) begin
         if (reset) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
         end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
         end
      end

      always_comb begin
         state_nx = state;
         cnt_nx   = cnt;
         unique case (state)
            RELEASED: begin
               if (pressed) begin
                  state_nx = PRESS_CHK;
                  cnt_nx   = CW'(1);
               end
            end
            PRESS_CHK: begin
               if (!pressed) begin
                  state_nx = RELEASED;
                  cnt_nx   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nx = HELD;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            HELD: begin
               if (!pressed) begin
                  state_nx = RELEASE_CHK;
                  cnt_nx   = CW'(1);
               end
            end
            RELEASE_CHK: begin
               if (pressed) begin
                  state_nx = HELD;
                  cnt_nx   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nx = RELEASED;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            default: begin
               state_nx = RELEASE_CHK;
               cnt_nx   = '0;
            end
         endcase
      end

      // Fire only on the PRESS_CHK->HELD edge itself; enable is sampled there, so a
      // later enable cannot resurrect a suppressed pulse.
      always_comb begin
         fire = 1'b0;
         if (state == PRESS_CHK && pressed && cnt == CNT_LAST && bus.enable) begin
            fire = 1'b1;
         end
      end

      always_ff @(posedge Clock) begin
         if (reset) begin
            pulse_q <= 1'b0;
            count_q <= '0;
         end else begin
            pulse_q <= fire;
            if (fire && count_q != {CNT_W{1'b1}}) begin
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

   assign bus.L           = g_chan[0].pulse_q;
   assign bus.R           = g_chan[1].pulse_q;
   assign bus.pressCountL = g_chan[0].count_q;
   assign bus.pressCountR = g_chan[1].count_q;
endmodule

// File: tb/tb_tow_press_pulser.sv
// tb/tb_tow_press_pulser.sv - scoreboard bench for tow_press_pulser (DEBOUNCE_CYCLES=4, CNT_W=2)
module tb_tow_press_pulser;
   localparam int D     = 4;
   localparam int CNT_W = 2;
   localparam int SAT   = (1 << CNT_W) - 1;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   logic Clock = 1'b0;
   logic reset;
   int   edge_n = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cl = 0;
   int   cr = 0;
   exp_t ql[$];
   exp_t qr[$];

   tow_press_pulser_if #(.CNT_W(CNT_W)) bus ();

   tow_press_pulser #(
      .DEBOUNCE_CYCLES(D),
      .ACTIVE_LOW(1'b1),
      .CNT_W(CNT_W)
   ) dut (
      .Clock(Clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) edge_n <= edge_n + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // Pulse is expected D+2 edges after the edge preceding the drive.
   task automatic expect_l();
      cl = (cl < SAT) ? cl + 1 : SAT;
      ql.push_back('{edge_n + D + 2, cl});
   endtask

   task automatic expect_r();
      cr = (cr < SAT) ? cr + 1 : SAT;
      qr.push_back('{edge_n + D + 2, cr});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      check("reset_L", int'(bus.L), 0);
      check("reset_R", int'(bus.R), 0);
      check("reset_cntL", int'(bus.pressCountL), 0);
      check("reset_cntR", int'(bus.pressCountR), 0);
      reset = 1'b0;
      cl = 0;
      cr = 0;
      tick(6);
   endtask

   task automatic settle(input string tag);
      tick(10);
      check({tag, "_pendL"}, ql.size(), 0);
      check({tag, "_pendR"}, qr.size(), 0);
      check({tag, "_cntL"}, int'(bus.pressCountL), cl);
      check({tag, "_cntR"}, int'(bus.pressCountR), cr);
   endtask

   always @(negedge Clock) begin
      exp_t e;
      if (!reset && bus.L) begin
         check("L_expected", int'(ql.size() > 0), 1);
         if (ql.size() > 0) begin
            e = ql.pop_front();
            check("L_cycle", edge_n, e.cyc);
            check("L_count", int'(bus.pressCountL), e.cnt);
         end
      end
      if (!reset && bus.R) begin
         check("R_expected", int'(qr.size() > 0), 1);
         if (qr.size() > 0) begin
            e = qr.pop_front();
            check("R_cycle", edge_n, e.cyc);
            check("R_count", int'(bus.pressCountR), e.cnt);
         end
      end
   end

   initial begin
      bus.keyL_raw = 1'b1;
      bus.keyR_raw = 1'b1;
      bus.enable   = 1'b1;
      reset        = 1'b1;
      tick(1);
      do_reset();

      // Clean left press held 20 cycles.
      bus.keyL_raw = 1'b0; expect_l();
      tick(20);
      bus.keyL_raw = 1'b1;
      tick(8);
      settle("clean");

      // Right bounce: 2 low, 1 high, 2 low, 1 high, then held low.
      do_reset();
      bus.keyR_raw = 1'b0; tick(2);
      bus.keyR_raw = 1'b1; tick(1);
      bus.keyR_raw = 1'b0; tick(2);
      bus.keyR_raw = 1'b1; tick(1);
      bus.keyR_raw = 1'b0; expect_r();
      tick(20);
      bus.keyR_raw = 1'b1;
      tick(8);
      settle("bounce");

      // Release glitch while held, then full release and second press.
      do_reset();
      bus.keyL_raw = 1'b0; expect_l();
      tick(12);
      bus.keyL_raw = 1'b1; tick(2);
      bus.keyL_raw = 1'b0; tick(10);
      bus.keyL_raw = 1'b1; tick(6);
      bus.keyL_raw = 1'b0; expect_l();
      tick(12);
      bus.keyL_raw = 1'b1;
      tick(8);
      settle("relbounce");

      // Simultaneous presses.
      do_reset();
      bus.keyL_raw = 1'b0;
      bus.keyR_raw = 1'b0;
      expect_l();
      expect_r();
      tick(12);
      bus.keyL_raw = 1'b1;
      bus.keyR_raw = 1'b1;
      tick(8);
      settle("simul");

      // Enable low during press; raising it while held must not fire.
      do_reset();
      bus.enable   = 1'b0;
      bus.keyL_raw = 1'b0;
      tick(12);
      bus.enable = 1'b1;
      tick(10);
      check("en_no_count", int'(bus.pressCountL), 0);
      bus.keyL_raw = 1'b1;
      tick(8);
      bus.keyL_raw = 1'b0; expect_l();
      tick(12);
      bus.keyL_raw = 1'b1;
      tick(8);
      settle("enable");

      // Button held through reset is absorbed.
      bus.keyL_raw = 1'b0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      cl = 0;
      cr = 0;
      tick(12);
      bus.keyL_raw = 1'b1;
      tick(8);
      settle("heldreset");

      // Five presses saturate a 2-bit counter at 3.
      for (int i = 0; i < 5; i++) begin
         bus.keyL_raw = 1'b0; expect_l();
         tick(10);
         bus.keyL_raw = 1'b1;
         tick(8);
      end
      settle("saturate");
      check("sat_value", int'(bus.pressCountL), SAT);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
